// File: rtl/sound_pkg.sv
// sound_pkg: tone selector encodings shared by the speaker tone generator.
package sound_pkg;
   localparam logic [1:0] TONE_NONE = 2'd0;
   localparam logic [1:0] TONE_HIT  = 2'd1;
   localparam logic [1:0] TONE_WALL = 2'd2;
   localparam logic [1:0] TONE_GOAL = 2'd3;
endpackage

// File: rtl/tone_divider.sv
// tone_divider: half-period counter driving a toggle flop to make a 50% square wave.
module tone_divider #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [CNT_W-1:0] half,
   input  logic             load_phase,
   output logic             out
);
   logic [CNT_W-1:0] cnt;
   // half of 2**CNT_W truncates to 0; half-1 then wraps to all ones, which is still correct
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         out <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         out <= 1'b0;
      end else if (load_phase)
         cnt <= '0;
      else if (cnt == half - CNT_W'(1)) begin
         cnt <= '0;
         out <= ~out;
      end else
         cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/sound_tone_gen.sv
// sound_tone_gen: prioritised event tones (goal > wall > hit) as one speaker square wave;
// the goal tone warbles between two pitches every GOAL_STEP cycles.
module sound_tone_gen
   import sound_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int HIT_HALF    = 25000,
   parameter int WALL_HALF   = 50000,
   parameter int GOAL_HALF_A = 20000,
   parameter int GOAL_HALF_B = 30000,
   parameter int GOAL_STEP   = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sound_en,
   input  logic       hit_snd,
   input  logic       wall_snd,
   input  logic       goal_snd,
   output logic       spk,
   output logic [1:0] tone_sel,
   output logic       active
);
   localparam int W_W = $clog2(GOAL_STEP + 1);
   logic [1:0]       req_sel;
   logic [CNT_W-1:0] half;
   logic [W_W-1:0]   wcnt;
   logic             phase;
   logic             clr;
   logic             load_phase;
   always_comb begin
      req_sel = !sound_en ? TONE_NONE : goal_snd ? TONE_GOAL : wall_snd ? TONE_WALL :
                hit_snd ? TONE_HIT : TONE_NONE;
      half    = tone_sel == TONE_HIT  ? CNT_W'(HIT_HALF)  :
                tone_sel == TONE_WALL ? CNT_W'(WALL_HALF) :
                phase ? CNT_W'(GOAL_HALF_B) : CNT_W'(GOAL_HALF_A);
   end
   // idle holds the divider cleared so spk stays low without a dedicated enable
   assign clr        = req_sel != tone_sel || tone_sel == TONE_NONE;
   assign load_phase = tone_sel == TONE_GOAL && wcnt == W_W'(GOAL_STEP - 1);
   assign active     = tone_sel != TONE_NONE;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tone_sel <= TONE_NONE;
         wcnt     <= '0;
         phase    <= 1'b0;
      end else if (req_sel != tone_sel) begin
         tone_sel <= req_sel;
         wcnt     <= '0;
         phase    <= 1'b0;
      end else if (tone_sel == TONE_GOAL) begin
         wcnt  <= load_phase ? '0 : wcnt + W_W'(1);
         phase <= load_phase ? ~phase : phase;
      end
   tone_divider #(.CNT_W(CNT_W)) u_div (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .half      (half),
      .load_phase(load_phase),
      .out       (spk)
   );
endmodule

// File: tb/tb_sound_tone_gen.sv
// tb_sound_tone_gen: directed checks of priority, latency, preemption, warble, mute and async reset.
module tb_sound_tone_gen;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sound_en = 1'b1;
   logic       hit_snd = 1'b0;
   logic       wall_snd = 1'b0;
   logic       goal_snd = 1'b0;
   logic       spk;
   logic [1:0] tone_sel;
   logic       active;
   int         checks = 0;
   int         failures = 0;
   logic [80:0] tog;
   logic       exp_spk;

   sound_tone_gen #(
      .CNT_W(8), .HIT_HALF(4), .WALL_HALF(6), .GOAL_HALF_A(3), .GOAL_HALF_B(5), .GOAL_STEP(20)
   ) dut (
      .clk(clk), .rst(rst), .sound_en(sound_en), .hit_snd(hit_snd), .wall_snd(wall_snd),
      .goal_snd(goal_snd), .spk(spk), .tone_sel(tone_sel), .active(active)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_spk"}, {1'b0, spk}, 2'd0);
      check({tag, "_sel"}, tone_sel, 2'd0);
      check({tag, "_act"}, {1'b0, active}, 2'd0);
   endtask

   initial begin
      tick(2);
      check_idle("reset");
      rst = 1'b0;
      tick(2);
      check_idle("idle");
      // 1: hit tone, half-period 4
      hit_snd = 1'b1;
      tick();
      check("hit_sel_e0", tone_sel, 2'd1);
      check("hit_act_e0", {1'b0, active}, 2'd1);
      check("hit_spk_e0", {1'b0, spk}, 2'd0);
      tick(3);
      check("hit_spk_e3", {1'b0, spk}, 2'd0);
      tick();
      check("hit_spk_e4", {1'b0, spk}, 2'd1);
      tick(3);
      check("hit_spk_e7", {1'b0, spk}, 2'd1);
      tick();
      check("hit_spk_e8", {1'b0, spk}, 2'd0);
      tick(4);
      check("hit_spk_e12", {1'b0, spk}, 2'd1);
      hit_snd = 1'b0;
      tick();
      check_idle("hit_rel");
      // 2: priority goal over hit, wall added later
      hit_snd = 1'b1;
      goal_snd = 1'b1;
      tick();
      check("pri_sel_e0", tone_sel, 2'd3);
      tick(2);
      check("pri_spk_e2", {1'b0, spk}, 2'd0);
      tick();
      check("pri_spk_e3", {1'b0, spk}, 2'd1);
      wall_snd = 1'b1;
      tick();
      check("pri_sel_wall", tone_sel, 2'd3);
      check("pri_spk_e4", {1'b0, spk}, 2'd1);
      tick(2);
      check("pri_spk_e6", {1'b0, spk}, 2'd0);
      {hit_snd, wall_snd, goal_snd} = 3'b000;
      tick();
      check_idle("pri_rel");
      // 3: wall preempts a hit while spk is high
      hit_snd = 1'b1;
      tick(5);
      check("pre_hit_spk", {1'b0, spk}, 2'd1);
      wall_snd = 1'b1;
      tick();
      check("pre_sel", tone_sel, 2'd2);
      check("pre_spk0", {1'b0, spk}, 2'd0);
      tick(5);
      check("pre_spk5", {1'b0, spk}, 2'd0);
      tick();
      check("pre_spk6", {1'b0, spk}, 2'd1);
      {hit_snd, wall_snd} = 2'b00;
      tick();
      check_idle("pre_rel");
      // 4: goal warble, half 3 for 20 cycles then 5, toggles at hand-derived edges
      tog = '0;
      foreach (tog[i]) tog[i] = (i inside {3, 6, 9, 12, 15, 18, 25, 30, 35, 43, 46, 49, 52, 55, 58, 65, 70, 75});
      exp_spk = 1'b0;
      goal_snd = 1'b1;
      tick();
      check("warb_sel", tone_sel, 2'd3);
      for (int e = 1; e <= 80; e++) begin
         tick();
         exp_spk = exp_spk ^ tog[e];
         check($sformatf("warb_spk_e%0d", e), {1'b0, spk}, {1'b0, exp_spk});
      end
      goal_snd = 1'b0;
      tick();
      check_idle("warb_rel");
      // 5: mute with inputs high, then unmute restarts from zero
      wall_snd = 1'b1;
      hit_snd = 1'b1;
      sound_en = 1'b0;
      tick();
      check_idle("mute_e0");
      tick(7);
      check_idle("mute_e7");
      sound_en = 1'b1;
      tick();
      check("unmute_sel", tone_sel, 2'd2);
      tick(5);
      check("unmute_spk5", {1'b0, spk}, 2'd0);
      tick();
      check("unmute_spk6", {1'b0, spk}, 2'd1);
      hit_snd = 1'b0;
      // 6: async reset between edges while spk is high
      #2;
      rst = 1'b1;
      #1;
      check_idle("areset");
      tick();
      check_idle("areset_hold");
      rst = 1'b0;
      tick();
      check("rst_sel", tone_sel, 2'd2);
      tick(5);
      check("rst_spk5", {1'b0, spk}, 2'd0);
      tick();
      check("rst_spk6", {1'b0, spk}, 2'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
